// File: rtl/qam_frame_scheduler.sv
// Packs IW-bit words into N-symbol QAM16/QAM32 frames; 1-cycle emit latency once k*N bits are held; in_ready low while a frame waits on out_ready.
// Optional QAM_SCHED_STATS_EN adds frame_cnt/pad_cnt outputs; mode switches only at frame boundaries.
module qam_frame_scheduler #(
    parameter int N      = 16,
    parameter int W      = 16,
    parameter int IW     = 16,
    parameter int LAST16 = 17727,
    parameter int LAST32 = 17725
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IW-1:0]    in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             cfg_mode,
    input  logic             cfg_we,
    input  logic             flush,
    output logic [5*N-1:0]   out_frame,
    output logic             out_mode,
    output logic [W-1:0]     out_last,
    output logic             out_flushed,
    output logic             out_valid,
    input  logic             out_ready
`ifdef QAM_SCHED_STATS_EN
    ,
    output logic [31:0]      frame_cnt,
    output logic [31:0]      pad_cnt
`endif
);

    localparam int FW = 5 * N;
    localparam int AW = FW + IW;
    localparam int CW = $clog2(AW + 1);

    typedef enum logic {S_FILL, S_EMIT} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_mode;
    logic            r_pend_mode;
    logic            r_flush_pend;
    logic [FW-1:0]   r_out_frame;
    logic            r_out_mode;
    logic [W-1:0]    r_out_last;
    logic            r_out_flushed;
    logic            r_out_valid;

    logic [CW-1:0]   w_kn;
    logic [FW-1:0]   w_mask_kn;
    logic            w_in_ready;
    logic            w_accept;
    logic [AW-1:0]   w_acc_new;
    logic [CW-1:0]   w_cnt_new;
    logic            w_do_full;
    logic            w_do_flush;
    logic            w_hs;
    logic            w_mode_upd;
    logic            w_pend_next;
    logic [W-1:0]    w_last_next;

    assign w_kn        = r_mode ? CW'(5 * N) : CW'(4 * N);
    assign w_mask_kn   = r_mode ? {FW{1'b1}} : {{N{1'b0}}, {(4 * N){1'b1}}};
    assign w_in_ready  = !rst && (r_state == S_FILL) && (r_cnt < w_kn);
    assign w_accept    = in_valid && w_in_ready;
    // Bits at and above r_cnt are always zero, so OR-ing places the word at acc[cnt +: IW].
    assign w_acc_new   = w_accept ? (r_acc | (AW'(in_data) << r_cnt)) : r_acc;
    assign w_cnt_new   = w_accept ? (r_cnt + CW'(IW)) : r_cnt;
    assign w_pend_next = cfg_we ? cfg_mode : r_pend_mode;
    assign w_last_next = w_pend_next ? W'(LAST32) : W'(LAST16);

    always_comb begin
        w_state_nxt = r_state;
        w_do_full   = 1'b0;
        w_do_flush  = 1'b0;
        w_hs        = 1'b0;
        w_mode_upd  = 1'b0;
        case (r_state)
            S_FILL: begin
                w_do_full  = (r_cnt >= w_kn);
                w_do_flush = !w_do_full && (flush || r_flush_pend) &&
                             (w_cnt_new != '0) && (w_cnt_new < w_kn);
                w_mode_upd = (r_cnt == '0) && !w_accept;
                if (w_do_full || w_do_flush)
                    w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                w_hs       = r_out_valid && out_ready;
                w_mode_upd = w_hs;
                if (w_hs)
                    w_state_nxt = S_FILL;
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_FILL;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc         <= '0;
            r_cnt         <= '0;
            r_mode        <= 1'b0;
            r_pend_mode   <= 1'b0;
            r_flush_pend  <= 1'b0;
            r_out_frame   <= '0;
            r_out_mode    <= 1'b0;
            r_out_last    <= W'(LAST16);
            r_out_flushed <= 1'b0;
            r_out_valid   <= 1'b0;
        end else begin
            r_pend_mode <= w_pend_next;
            if (r_state == S_FILL) begin
                if (w_do_full) begin
                    r_out_frame   <= r_acc[FW-1:0] & w_mask_kn;
                    r_acc         <= r_acc >> w_kn;
                    r_cnt         <= r_cnt - w_kn;
                    r_out_mode    <= r_mode;
                    r_out_flushed <= 1'b0;
                    r_out_valid   <= 1'b1;
                end else if (w_do_flush) begin
                    r_out_frame   <= w_acc_new[FW-1:0];
                    r_acc         <= '0;
                    r_cnt         <= '0;
                    r_out_mode    <= r_mode;
                    r_out_flushed <= 1'b1;
                    r_out_valid   <= 1'b1;
                end else begin
                    r_acc <= w_acc_new;
                    r_cnt <= w_cnt_new;
                end
                // A flush that cannot be served now (frame full) waits; one with no bits is dropped.
                if (w_do_flush)
                    r_flush_pend <= 1'b0;
                else if (flush && (w_do_full || w_cnt_new >= w_kn))
                    r_flush_pend <= 1'b1;
                else if (w_cnt_new == '0)
                    r_flush_pend <= 1'b0;
            end else begin
                if (flush)
                    r_flush_pend <= 1'b1;
                if (w_hs) begin
                    r_out_valid   <= 1'b0;
                    r_out_flushed <= 1'b0;
                end
            end
            if (w_mode_upd) begin
                r_mode     <= w_pend_next;
                r_out_mode <= w_pend_next;
                r_out_last <= w_last_next;
            end
        end
    end

`ifdef QAM_SCHED_STATS_EN
    logic [31:0] r_frame_cnt;
    logic [31:0] r_pad_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_pad_cnt   <= '0;
        end else begin
            if (w_hs)
                r_frame_cnt <= r_frame_cnt + 32'd1;
            if (w_do_flush)
                r_pad_cnt <= r_pad_cnt + 32'(w_kn - w_cnt_new);
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign pad_cnt   = r_pad_cnt;
`endif

    assign in_ready    = w_in_ready;
    assign out_frame   = r_out_frame;
    assign out_mode    = r_out_mode;
    assign out_last    = r_out_last;
    assign out_flushed = r_out_flushed;
    assign out_valid   = r_out_valid;

endmodule

// File: tb/tb_qam_frame_scheduler.sv
// Scoreboard bench for qam_frame_scheduler: stimulus pushes expected frames, a negedge monitor pops and compares.
module tb_qam_frame_scheduler;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic          cfg_mode;
    logic          cfg_we;
    logic          flush;
    logic [79:0]   out_frame;
    logic          out_mode;
    logic [15:0]   out_last;
    logic          out_flushed;
    logic          out_valid;
    logic          out_ready;
`ifdef QAM_SCHED_STATS_EN
    logic [31:0]   frame_cnt;
    logic [31:0]   pad_cnt;
`endif

    qam_frame_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cfg_mode    (cfg_mode),
        .cfg_we      (cfg_we),
        .flush       (flush),
        .out_frame   (out_frame),
        .out_mode    (out_mode),
        .out_last    (out_last),
        .out_flushed (out_flushed),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
`ifdef QAM_SCHED_STATS_EN
        ,
        .frame_cnt   (frame_cnt),
        .pad_cnt     (pad_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [79:0] frame;
        logic        mode;
        logic [15:0] last;
        logic        fl;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   hs_cnt   = 0;

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic [79:0] frame, input logic mode, input logic fl);
        exp_t e;
        e.frame = frame;
        e.mode  = mode;
        e.last  = mode ? 16'd17725 : 16'd17727;
        e.fl    = fl;
        exp_q.push_back(e);
    endtask

    // Monitor: every handshake seen at the negedge is matched against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            exp_t e;
            hs_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame: got %h want none", out_frame);
            end else begin
                e = exp_q.pop_front();
                check("frame",   out_frame,          e.frame);
                check("mode",    80'(out_mode),      80'(e.mode));
                check("last",    80'(out_last),      80'(e.last));
                check("flushed", 80'(out_flushed),   80'(e.fl));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] d);
        int  n = 0;
        logic ok;
        in_data  = d;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok === 1'b1) break;
            n++;
            if (n > 300) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: got in_ready=0 want 1 for word %h", d);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_cfg(input logic m);
        cfg_mode = m;
        cfg_we   = 1'b1;
        tick(1);
        cfg_we   = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick(1);
            n++;
        end
        tick(2);
        check({name, "_drained"}, 80'(exp_q.size()), 80'd0);
    endtask

    initial begin
        int hs_before;
        int n;
        rst = 1'b1; in_data = '0; in_valid = 1'b1; cfg_mode = 1'b0; cfg_we = 1'b0;
        flush = 1'b0; out_ready = 1'b1;
        tick(3);
        @(negedge clk);
        check("in_ready_in_reset", 80'(in_ready), 80'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid",   80'(out_valid),   80'd0);
        check("rst_out_frame",   out_frame,        80'd0);
        check("rst_out_mode",    80'(out_mode),    80'd0);
        check("rst_out_last",    80'(out_last),    80'd17727);
        check("rst_out_flushed", 80'(out_flushed), 80'd0);
        @(posedge clk); #1;

        // QAM16 full frame
        push_exp(80'h0000_FEDCBA9876543210, 1'b0, 1'b0);
        send_word(16'h3210); send_word(16'h7654); send_word(16'hBA98); send_word(16'hFEDC);
        drain("qam16");

        // QAM32 full frame after an idle mode change
        pulse_cfg(1'b1);
        tick(2);
        push_exp({16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) send_word(16'(i));
        drain("qam32");

        // Backpressure: frame must hold while out_ready is low
        out_ready = 1'b0;
        push_exp({16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111}, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) send_word(16'(i * 16'h1111));
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin tick(1); n++; end
        in_data = 16'hEEEE; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_valid",    80'(out_valid), 80'd1);
            check("bp_frame",    out_frame,      {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111});
            check("bp_in_ready", 80'(in_ready),  80'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        hs_before = hs_cnt;
        out_ready = 1'b1;
        tick(4);
        check("bp_one_handshake", 80'(hs_cnt), 80'(hs_before + 1));
        drain("bp");

        // Mid-frame mode switch: QAM16 frame, then QAM32 frame from word 5
        pulse_cfg(1'b0);
        tick(2);
        push_exp({16'h0000, 16'h1004, 16'h1003, 16'h1002, 16'h1001}, 1'b0, 1'b0);
        push_exp({16'h1009, 16'h1008, 16'h1007, 16'h1006, 16'h1005}, 1'b1, 1'b0);
        send_word(16'h1001); send_word(16'h1002);
        pulse_cfg(1'b1);
        for (int i = 3; i <= 9; i++) send_word(16'h1000 + 16'(i));
        drain("switch");

        // Flush of a partial QAM32 frame, then a flush with nothing buffered
        push_exp(80'h0000_0000_0000_0000_ABCD, 1'b1, 1'b1);
        send_word(16'hABCD);
        pulse_flush();
        drain("flush");
        hs_before = hs_cnt;
        pulse_flush();
        tick(6);
        check("empty_flush_no_frame", 80'(hs_cnt), 80'(hs_before));

        // Word accepted together with flush is included before padding
        push_exp(80'h1234, 1'b1, 1'b1);
        in_data = 16'h1234; in_valid = 1'b1; flush = 1'b1;
        tick(1);
        in_valid = 1'b0; flush = 1'b0;
        drain("flush_with_word");

        // Reset mid-frame discards buffered bits and the QAM32 mode
        send_word(16'hDEAD); send_word(16'hBEEF); send_word(16'hCAFE);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        push_exp({16'h0000, 16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A}, 1'b0, 1'b0);
        send_word(16'h0A0A); send_word(16'h0B0B); send_word(16'h0C0C); send_word(16'h0D0D);
        drain("reset_mid");

        check("total_frames", 80'(hs_cnt), 80'd8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qam_frame_scheduler.md
Name: qam_frame_scheduler

Overview:
Packs a serial word stream into one parallel symbol frame per transfer for the QAM16/QAM32 mappers. Each frame holds N symbols of k bits (k=4 for QAM16, k=5 for QAM32). The block also drives the outer-constellation amplitude ("last") and the active mode to the mapper stage. Mode changes take effect only at frame boundaries, so the mapper never sees a frame with mixed modulation.

Parameters:
N, 16, symbols per frame (parallel mapper lanes)
W, 16, amplitude bus width
IW, 16, input word width; must satisfy IW <= 4*N
LAST16, 17727, outer amplitude for QAM16 (3*D scaled by 2^15)
LAST32, 17725, outer amplitude for QAM32; must be a multiple of 5

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_data  in  IW  input bits; bit 0 is the oldest
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid && in_ready
cfg_mode  in  1  requested mode: 0=QAM16, 1=QAM32
cfg_we  in  1  one-cycle strobe; latches cfg_mode as the pending mode
flush  in  1  one-cycle strobe; zero-pad and emit the partial frame
out_frame  out  5*N  packed symbols; symbol i at bits [k*i +: k]
out_mode  out  1  mode of out_frame
out_last  out  W  LAST16 or LAST32, selected by the active mode
out_flushed  out  1  out_frame contains zero padding
out_valid  out  1  frame valid
out_ready  in  1  frame accepted when out_valid && out_ready

Behaviour:
- Reset values: state FILL; acc=0; cnt=0; active and pending mode=0; flush_pend=0; out_frame=0; out_mode=0; out_last=LAST16; out_flushed=0; out_valid=0; in_ready=0 during reset.
- Accumulator acc is 5*N+IW bits wide. cnt holds the number of valid bits, range 0..5*N+IW-1. An accepted word is written at acc[cnt +: IW], and cnt increases by IW.
- KN = k*N, where k comes from the active mode.
- State FILL:
  - in_ready = (cnt < KN).
  - If cnt >= KN: on the next edge, out_frame <= acc[KN-1:0] with bits above KN forced to 0; acc shifts right by KN; cnt -= KN; out_valid <= 1; go to EMIT. Latency is one cycle after cnt reaches KN.
  - Else if flush or flush_pend, and 0 < cnt < KN: emit acc[cnt-1:0] zero-extended; cnt <= 0; out_flushed <= 1; go to EMIT.
  - A flush with cnt == 0 is dropped and produces no frame.
- State EMIT:
  - in_ready = 0.
  - out_frame, out_mode and out_flushed stay stable while out_valid && !out_ready.
  - A flush arriving in EMIT sets flush_pend.
  - On handshake: out_valid <= 0; out_flushed <= 0; active mode <= pending mode; go to FILL.
  - flush_pend clears when its frame is emitted.
- Mode application:
  - cfg_we always updates the pending mode; the last write wins.
  - The active mode is updated at the EMIT handshake.
  - In FILL, the active mode is also updated when cnt == 0 and no word is accepted in that cycle.
  - Residual bits carried past a boundary start the next frame and are interpreted in the new mode.
- out_mode and out_last are registered and change only when the active mode changes. They are captured alongside out_frame at emit.
- Simultaneous events:
  - A word accepted in the same cycle as a flush is included before padding.
  - cfg_we together with a handshake: the new cfg_mode applies to the next frame.
- Reset mid-operation discards all buffered bits and the in-flight frame.

Optional Feature:
QAM_SCHED_STATS_EN
- Defined: adds output ports frame_cnt[31:0] and pad_cnt[31:0].
  - frame_cnt increments on each out handshake.
  - pad_cnt adds the number of padded bits on each flushed frame.
  - Both counters wrap, and both clear on rst.
- Undefined: no counters and no extra ports.

Test Plan:
- QAM16: send 0x3210, 0x7654, 0xBA98, 0xFEDC with out_ready=1 -> one frame with out_frame[63:0]=0xFEDCBA9876543210, [79:64]=0, out_mode=0, out_last=17727, out_flushed=0.
- QAM32: cfg_we with cfg_mode=1 while idle, then 5 words 0x0001..0x0005 -> one frame; out_frame[4:0]=1; out_frame[20:16]=2; out_mode=1, out_last=17725.
- Backpressure: frame pending with out_ready=0 for 10 cycles -> out_valid=1 and out_frame unchanged; in_ready=0. Release out_ready -> exactly one handshake.
- Mid-frame switch: QAM16 with 2 words sent, cfg_we mode=1, then 7 more words -> first frame is QAM16 (64 bits, out_last=17727); second frame is QAM32 starting at word 5, out_last=17725.
- Flush: QAM32, one word 0xABCD, then flush -> out_frame=0x...0000ABCD, out_flushed=1, cnt=0 afterwards. A second flush produces no frame.
- Reset mid-frame: 3 QAM16 words, then rst, then 4 new words -> frame contains only the new words; mode=0.
